// File: rtl/puf_auth_multichannel_dr.sv
// JTAG data register and response sequencer for a bank of NCH PUF instances.
// A shifted word selects a channel and challenge. UPDATE_DR launches one
// generate pulse. The sequencer then waits for that channel's ready, with a
// timeout, and records the response and status for the next CAPTURE_DR.
module puf_auth_multichannel_dr #(
    parameter int                CHAL_W      = 5,
    parameter int                RESP_W      = 16,
    parameter int                NCH         = 4,
    parameter int                IR_W        = 4,
    parameter logic [IR_W-1:0]   IR_PUF_AUTH = 4'b0110,
    parameter int                TIMEOUT     = 64,
    parameter logic [RESP_W-1:0] DEAD_PAT    = 16'hDEAD,
    localparam int               CH_W        = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int               DR_W        = RESP_W + 2
) (
    input  logic                  TCK,
    input  logic                  TRST,
    input  logic                  TDI,
    input  logic [3:0]            tap_state,
    input  logic [IR_W-1:0]       IR,
    output logic [CHAL_W-1:0]     puf_challenge,
    output logic [CH_W-1:0]       puf_sel,
    output logic                  puf_generate,
    input  logic [NCH*RESP_W-1:0] puf_response,
    input  logic [NCH-1:0]        puf_ready,
    output logic                  puf_tdo,
    output logic                  counter_start,
    output logic [RESP_W-1:0]     puf_number,
    output logic                  auth_busy,
    output logic                  auth_timeout
);

    localparam int              TO_W       = $clog2(TIMEOUT + 1);
    localparam logic [3:0]      CAPTURE_DR = 4'b0110;
    localparam logic [3:0]      SHIFT_DR   = 4'b0010;
    localparam logic [3:0]      UPDATE_DR  = 4'b0101;
    localparam logic [CH_W-1:0] CH_MAX     = CH_W'(NCH - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state;
    logic [DR_W-1:0]   dr;
    logic [TO_W-1:0]   timer;
    logic [RESP_W-1:0] resp_hold;
    logic              valid;
    logic              dr_en;
    logic [CH_W-1:0]   ch_field;
    logic [CH_W-1:0]   ch_clamped;
    logic [RESP_W-1:0] resp_sel;
    logic              ready_sel;

    assign dr_en      = (IR == IR_PUF_AUTH);
    assign ch_field   = dr[CHAL_W +: CH_W];
    assign puf_tdo    = dr[0];
    assign puf_number = resp_hold;
    assign auth_busy  = (state == WAIT);

    // Out-of-range channel numbers fall back to the last physical channel
    always_comb begin
        ch_clamped = ch_field;
        if (int'(ch_field) >= NCH) ch_clamped = CH_MAX;
    end

    // Route the currently selected channel's response and ready
    always_comb begin
        resp_sel  = '0;
        ready_sel = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (puf_sel == CH_W'(k)) begin
                resp_sel  = puf_response[k*RESP_W +: RESP_W];
                ready_sel = puf_ready[k];
            end
        end
    end

    // DR capture/shift/update plus the IDLE/WAIT response sequencer
    always_ff @(posedge TCK) begin
        if (TRST) begin
            state         <= IDLE;
            dr            <= '0;
            timer         <= '0;
            resp_hold     <= '0;
            valid         <= 1'b0;
            auth_timeout  <= 1'b0;
            puf_challenge <= '0;
            puf_sel       <= '0;
            puf_generate  <= 1'b0;
            counter_start <= 1'b0;
        end else begin
            puf_generate  <= 1'b0;
            counter_start <= 1'b0;
            if (dr_en) begin
                case (tap_state)
                    CAPTURE_DR: dr <= {auth_timeout, valid, resp_hold};
                    SHIFT_DR:   dr <= {TDI, dr[DR_W-1:1]};
                    UPDATE_DR: begin
                        if (state == IDLE) begin
                            puf_challenge <= dr[CHAL_W-1:0];
                            puf_sel       <= ch_clamped;
                            puf_generate  <= 1'b1;
                            timer         <= '0;
                            valid         <= 1'b0;
                            auth_timeout  <= 1'b0;
                            state         <= WAIT;
                        end
                    end
                    default: ;
                endcase
            end
            // The generate cycle still advances the timer, but ready is not
            // trusted while the PUF is only just seeing the request.
            if (state == WAIT) begin
                if (!puf_generate && ready_sel) begin
                    resp_hold     <= resp_sel;
                    valid         <= 1'b1;
                    counter_start <= 1'b1;
                    state         <= IDLE;
                end else if (timer == TO_W'(TIMEOUT - 1)) begin
                    resp_hold    <= DEAD_PAT;
                    auth_timeout <= 1'b1;
                    state        <= IDLE;
                end else begin
                    timer <= timer + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_puf_auth_multichannel_dr.sv
// Directed and randomized bench for puf_auth_multichannel_dr. The reference
// treats each operation as a transaction. A ready first seen d cycles after the
// generate cycle succeeds when d < TIMEOUT. Otherwise the op times out after
// TIMEOUT busy cycles.
module tb_puf_auth_multichannel_dr;

    localparam int          TIMEOUT = 64;
    localparam logic [15:0] DEAD    = 16'hDEAD;
    localparam logic [3:0]  AUTH_IR = 4'b0110;
    localparam logic [3:0]  T_CAP   = 4'b0110;
    localparam logic [3:0]  T_SH    = 4'b0010;
    localparam logic [3:0]  T_UPD   = 4'b0101;
    localparam logic [3:0]  T_IDLE  = 4'b1100;

    logic        TCK = 1'b0;
    logic        TRST, TDI;
    logic [3:0]  tap_state, IR;
    logic [4:0]  puf_challenge;
    logic [1:0]  puf_sel;
    logic        puf_generate, puf_tdo, counter_start, auth_busy, auth_timeout;
    logic [63:0] puf_response;
    logic [3:0]  puf_ready;
    logic [15:0] puf_number;

    int checks = 0;
    int failures = 0;
    int gen_cnt = 0;
    int cs_cnt = 0;
    logic [17:0] last_stat;

    puf_auth_multichannel_dr dut (
        .TCK(TCK), .TRST(TRST), .TDI(TDI), .tap_state(tap_state), .IR(IR),
        .puf_challenge(puf_challenge), .puf_sel(puf_sel), .puf_generate(puf_generate),
        .puf_response(puf_response), .puf_ready(puf_ready), .puf_tdo(puf_tdo),
        .counter_start(counter_start), .puf_number(puf_number),
        .auth_busy(auth_busy), .auth_timeout(auth_timeout)
    );

    initial forever #5 TCK = ~TCK;

    // Pulse counters: each posedge sees the value held during the finished cycle
    always @(posedge TCK) begin
        if (puf_generate === 1'b1) gen_cnt++;
        if (counter_start === 1'b1) cs_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge TCK);
    endtask

    task automatic capture();
        tap_state = T_CAP; tick(); tap_state = T_IDLE;
    endtask

    task automatic update();
        tap_state = T_UPD; tick(); tap_state = T_IDLE;
    endtask

    task automatic shift(input logic [17:0] din, output logic [17:0] dout);
        tap_state = T_SH;
        for (int i = 0; i < 18; i++) begin
            TDI = din[i];
            dout[i] = puf_tdo;
            tick();
        end
        tap_state = T_IDLE;
        TDI = 1'b0;
    endtask

    function automatic logic [17:0] mk_word(input logic [4:0] chal, input logic [1:0] ch);
        logic [17:0] w;
        w = 18'($urandom);
        w[4:0] = chal;
        w[6:5] = ch;
        return w;
    endfunction

    // Drive the PUF side until busy drops: noise on other channels, a spurious
    // ready on the selected channel in the generate cycle, real ready from d on.
    task automatic wait_done(input int c0, input int d, input int ch, input logic [15:0] resp,
                             output int cyc);
        int c;
        c = c0;
        while (auth_busy === 1'b1 && c < 200) begin
            puf_ready = 4'($urandom);
            puf_response = {$urandom, $urandom};
            puf_ready[ch] = (c == 0) || (d < TIMEOUT && c >= d);
            if (d < TIMEOUT && c >= d) puf_response[ch*16 +: 16] = resp;
            tick();
            c++;
        end
        puf_ready = '0;
        cyc = c;
    endtask

    // Checks shared by every completed op
    task automatic check_result(input string tag, input logic [4:0] chal, input int ch,
                                input logic [15:0] resp, input int d, input int cyc);
        logic        rdy;
        logic [15:0] exp_num;
        logic [17:0] dout;
        rdy = (d < TIMEOUT);
        exp_num = rdy ? resp : DEAD;
        tick();
        check({tag, "_busy_cycles"}, 64'(cyc), rdy ? 64'(d + 1) : 64'(TIMEOUT));
        check({tag, "_gen_pulses"}, 64'(gen_cnt), 64'd1);
        check({tag, "_cs_pulses"}, 64'(cs_cnt), rdy ? 64'd1 : 64'd0);
        check({tag, "_number"}, 64'(puf_number), 64'(exp_num));
        check({tag, "_flags"}, {62'd0, auth_busy, auth_timeout}, {62'd0, 1'b0, ~rdy});
        check({tag, "_chal_sel"}, {57'd0, puf_challenge, puf_sel}, {57'd0, chal, 2'(ch)});
        last_stat = {~rdy, rdy, exp_num};
        capture();
        shift(18'($urandom), dout);
        check({tag, "_capture"}, 64'(dout), 64'(last_stat));
    endtask

    task automatic do_op(input string tag, input logic [4:0] chal, input int ch,
                         input logic [15:0] resp, input int d);
        logic [17:0] junk;
        int cyc;
        gen_cnt = 0; cs_cnt = 0;
        shift(mk_word(chal, 2'(ch)), junk);
        update();
        check({tag, "_launch"}, {61'd0, puf_generate, auth_busy, auth_timeout}, {61'd0, 3'b110});
        wait_done(0, d, ch, resp, cyc);
        check_result(tag, chal, ch, resp, d, cyc);
    endtask

    initial begin
        logic [17:0] dout, junk;
        logic [4:0]  chal;
        logic [15:0] resp;
        int          cyc, ch;

        TRST = 1'b1; TDI = 1'b0; tap_state = T_IDLE; IR = AUTH_IR;
        puf_ready = '0; puf_response = '0; last_stat = '0;

        // Reset
        tick(); tick();
        TRST = 1'b0;
        check("reset_outs", {puf_challenge, puf_sel, puf_generate, counter_start, puf_tdo,
                             puf_number, auth_busy, auth_timeout}, 64'd0);
        capture();
        shift(18'h3FFFF, dout);
        check("reset_capture", 64'(dout), 64'd0);

        // Directed: ch2 ready three cycles after generate
        do_op("beef", 5'h15, 2, 16'hBEEF, 3);

        // Directed: ch1 never ready
        do_op("tmo", 5'($urandom), 1, 16'($urandom), TIMEOUT + 5);

        // Second UPDATE while waiting, ready on the final timeout cycle
        chal = 5'h0A; resp = 16'h1234; ch = 3;
        gen_cnt = 0; cs_cnt = 0;
        shift(mk_word(chal, 2'(ch)), junk);
        update();
        puf_ready = '0;
        shift(mk_word(5'h03, 2'd0), junk);
        update();
        check("midwait_ignored", {57'd0, puf_challenge, puf_sel}, {57'd0, chal, 2'(ch)});
        wait_done(19, TIMEOUT - 1, ch, resp, cyc);
        check_result("midwait", chal, ch, resp, TIMEOUT - 1, cyc);

        // Foreign IR: DR and sequencer untouched
        capture();
        gen_cnt = 0;
        IR = 4'b0001;
        capture();
        shift(18'($urandom), junk);
        update();
        tick();
        check("ir_other_idle", {61'd0, auth_busy, 2'(gen_cnt)}, 64'd0);
        check("ir_other_chal", 64'(puf_challenge), 64'(chal));
        IR = AUTH_IR;
        shift(18'($urandom), dout);
        check("ir_other_dr", 64'(dout), 64'(last_stat));

        // Reset in the middle of WAIT
        gen_cnt = 0; cs_cnt = 0;
        shift(mk_word(5'h1F, 2'd1), junk);
        update();
        for (int i = 0; i < 10; i++) tick();
        TRST = 1'b1;
        tick();
        TRST = 1'b0;
        tick();
        check("rst_wait_outs", {puf_challenge, puf_sel, puf_generate, counter_start,
                                puf_number, auth_busy, auth_timeout}, 64'd0);
        check("rst_wait_cs", 64'(cs_cnt), 64'd0);
        do_op("after_rst", 5'h0C, 0, 16'hA5C3, 7);

        // Randomized ops
        for (int n = 0; n < 8; n++) begin
            do_op("rand", 5'($urandom), int'($urandom_range(0, 3)), 16'($urandom),
                  int'($urandom_range(1, TIMEOUT + 6)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
